// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared slot type, select encodings and match helper
package pipe_hazard_ctrl_pkg;

  localparam int REG_W = 5;

  localparam logic [1:0] FWD_REGF = 2'd0;
  localparam logic [1:0] FWD_MEM  = 2'd1;
  localparam logic [1:0] FWD_WB   = 2'd2;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rwd;
    logic             wen;
    logic             is_load;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic             use_rs;
    logic             use_rt;
  } slot_t;

  localparam slot_t SLOT_BUBBLE = '0;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_e;

  // Register 0 is hardwired, so it can never be the subject of a hazard.
  function automatic logic src_match(logic use_src, logic [REG_W-1:0] src, slot_t s);
    return use_src && (src != '0) && s.valid && s.wen && (s.rwd == src);
  endfunction

  function automatic logic slot_hit(slot_t id, slot_t s);
    return src_match(id.use_rs, id.rs, s) || src_match(id.use_rt, id.rt, s);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hz_scoreboard.sv
// rtl/pipe_hazard_ctrl_hz_scoreboard.sv - EX/MEM/WB destination scoreboard with hazard and forward match
module pipe_hazard_ctrl_hz_scoreboard
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter bit FWD_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  slot_t      id_slot_i,
  input  logic       kill_i,
  output logic       hz_o,
  output logic [1:0] fwd_rs_sel_o,
  output logic [1:0] fwd_rt_sel_o
);

  slot_t ex_q, mem_q, wb_q;
  slot_t ex_d;
  logic  hit_ex, hit_mem, hit_wb;
  logic  sb_unused;

  assign ex_d = kill_i ? SLOT_BUBBLE : id_slot_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= SLOT_BUBBLE;
      mem_q <= SLOT_BUBBLE;
      wb_q  <= SLOT_BUBBLE;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  // A load in MEM is never a forward source; the load-use stall keeps it from arising.
  function automatic logic [1:0] pick_src(logic use_src, logic [REG_W-1:0] src);
    if (src_match(use_src, src, mem_q) && !mem_q.is_load) return FWD_MEM;
    if (src_match(use_src, src, wb_q)) return FWD_WB;
    return FWD_REGF;
  endfunction

  always_comb begin
    hit_ex       = slot_hit(id_slot_i, ex_q);
    hit_mem      = slot_hit(id_slot_i, mem_q);
    hit_wb       = slot_hit(id_slot_i, wb_q);
    hz_o         = 1'b0;
    fwd_rs_sel_o = FWD_REGF;
    fwd_rt_sel_o = FWD_REGF;
    if (FWD_EN) begin
      hz_o         = hit_ex && ex_q.is_load;
      fwd_rs_sel_o = pick_src(ex_q.use_rs, ex_q.rs);
      fwd_rt_sel_o = pick_src(ex_q.use_rt, ex_q.rt);
    end else begin
      hz_o = hit_ex || hit_mem || hit_wb;
    end
  end

  assign sb_unused = ^wb_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline hazard scheduler: stall/bubble control, forward selects, stall counter
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter bit FWD_EN = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [4:0]       id_rwd,
  input  logic             id_wen,
  input  logic             id_is_load,
  input  logic             flush,
  output logic             stall_if,
  output logic             stall_id,
  output logic             bubble_ex,
  output logic [1:0]       fwd_rs_sel,
  output logic [1:0]       fwd_rt_sel,
  output logic [CNT_W-1:0] stall_cnt
);

  slot_t            id_slot;
  logic             hz_raw, hz;
  logic [1:0]       sb_rs_sel, sb_rt_sel;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  assign id_slot = '{valid: 1'b1, rwd: id_rwd, wen: id_wen, is_load: id_is_load,
                     rs: id_rs, rt: id_rt, use_rs: id_use_rs, use_rt: id_use_rt};

  // Flush kills the ID instruction, so there is nothing left to stall for.
  assign hz = hz_raw && !flush && !rst;

  pipe_hazard_ctrl_hz_scoreboard #(
    .FWD_EN(FWD_EN)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .id_slot_i   (id_slot),
    .kill_i      (hz || flush),
    .hz_o        (hz_raw),
    .fwd_rs_sel_o(sb_rs_sel),
    .fwd_rt_sel_o(sb_rt_sel)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:   if (hz)  state_d = ST_STALL;
      ST_STALL: if (!hz) state_d = ST_RUN;
      default:           state_d = ST_RUN;
    endcase
    if (flush) state_d = ST_RUN;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hz && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_if   = hz;
  assign stall_id   = hz;
  assign bubble_ex  = (hz || flush) && !rst;
  assign fwd_rs_sel = rst ? FWD_REGF : sb_rs_sel;
  assign fwd_rt_sel = rst ? FWD_REGF : sb_rt_sel;
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl (forwarding, interlock, saturation)
module tb_pipe_hazard_ctrl;

  logic       clk, rst, flush;
  logic [4:0] id_rs, id_rt, id_rwd;
  logic       id_use_rs, id_use_rt, id_wen, id_is_load;

  logic        f1_sif, f1_sid, f1_bub, f0_sif, f0_sid, f0_bub, s2_sif, s2_sid, s2_bub;
  logic [1:0]  f1_frs, f1_frt, f0_frs, f0_frt, s2_frs, s2_frt;
  logic [15:0] f1_cnt, f0_cnt;
  logic [1:0]  s2_cnt;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 0;

  pipe_hazard_ctrl #(.FWD_EN(1'b1), .CNT_W(16)) u_f1 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .id_rwd(id_rwd), .id_wen(id_wen), .id_is_load(id_is_load),
    .flush(flush), .stall_if(f1_sif), .stall_id(f1_sid), .bubble_ex(f1_bub),
    .fwd_rs_sel(f1_frs), .fwd_rt_sel(f1_frt), .stall_cnt(f1_cnt));

  pipe_hazard_ctrl #(.FWD_EN(1'b0), .CNT_W(16)) u_f0 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .id_rwd(id_rwd), .id_wen(id_wen), .id_is_load(id_is_load),
    .flush(flush), .stall_if(f0_sif), .stall_id(f0_sid), .bubble_ex(f0_bub),
    .fwd_rs_sel(f0_frs), .fwd_rt_sel(f0_frt), .stall_cnt(f0_cnt));

  pipe_hazard_ctrl #(.FWD_EN(1'b0), .CNT_W(2)) u_s2 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .id_rwd(id_rwd), .id_wen(id_wen), .id_is_load(id_is_load),
    .flush(flush), .stall_if(s2_sif), .stall_id(s2_sid), .bubble_ex(s2_bub),
    .fwd_rs_sel(s2_frs), .fwd_rt_sel(s2_frt), .stall_cnt(s2_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: each issued instruction is stamped with the cycle it entered EX; its age
  // (0=EX, 1=MEM, 2=WB) says where it sits now.
  typedef struct {
    int       t;
    bit [4:0] rwd, rs, rt;
    bit       wen, ld, urs, urt;
  } rec_t;

  rec_t q1[$];
  rec_t q0[$];
  int   cyc = 0;
  int   cnt1 = 0;
  int   cnt0 = 0;

  function automatic bit reads(rec_t r);
    return r.wen && r.rwd != 0 &&
           ((id_use_rs && id_rs == r.rwd) || (id_use_rt && id_rt == r.rwd));
  endfunction

  function automatic bit m_hz(bit fwd, rec_t q[$]);
    bit h = 0;
    if (rst || flush) return 0;
    foreach (q[i]) begin
      int age = cyc - q[i].t;
      if (fwd) begin
        if (age == 0 && q[i].ld && reads(q[i])) h = 1;
      end else if (age <= 2 && reads(q[i])) h = 1;
    end
    return h;
  endfunction

  function automatic int m_fwd(bit fwd, rec_t q[$], bit rt_side);
    bit       found = 0;
    bit [4:0] src = 0;
    bit       use_src = 0;
    int       res = 0;
    if (rst || !fwd) return 0;
    foreach (q[i]) if (cyc == q[i].t) begin
      found = 1;
      src = rt_side ? q[i].rt : q[i].rs;
      use_src = rt_side ? q[i].urt : q[i].urs;
    end
    if (!found || !use_src || src == 0) return 0;
    foreach (q[i]) if (cyc - q[i].t == 2 && q[i].wen && q[i].rwd == src) res = 2;
    foreach (q[i]) if (cyc - q[i].t == 1 && q[i].wen && q[i].rwd == src && !q[i].ld) res = 1;
    return res;
  endfunction

  function automatic rec_t cur_rec();
    rec_t r;
    r.t = cyc + 1; r.rwd = id_rwd; r.rs = id_rs; r.rt = id_rt;
    r.wen = id_wen; r.ld = id_is_load; r.urs = id_use_rs; r.urt = id_use_rt;
    return r;
  endfunction

  always @(posedge clk) begin
    bit h1, h0;
    h1 = m_hz(1, q1);
    h0 = m_hz(0, q0);
    if (rst) begin
      q1.delete(); q0.delete(); cnt1 = 0; cnt0 = 0;
    end else begin
      if (!h1 && !flush) q1.push_back(cur_rec());
      if (!h0 && !flush) q0.push_back(cur_rec());
      if (h1) cnt1++;
      if (h0) cnt0++;
    end
    cyc++;
    while (q1.size() > 0 && cyc - q1[0].t > 2) void'(q1.pop_front());
    while (q0.size() > 0 && cyc - q0[0].t > 2) void'(q0.pop_front());
  end

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    bit h1, h0;
    h1 = m_hz(1, q1);
    h0 = m_hz(0, q0);
    chk("f1.stall_if", f1_sif, h1);
    chk("f1.stall_id", f1_sid, h1);
    chk("f1.bubble_ex", f1_bub, (h1 || flush) && !rst);
    chk("f1.fwd_rs", f1_frs, m_fwd(1, q1, 0));
    chk("f1.fwd_rt", f1_frt, m_fwd(1, q1, 1));
    chk("f1.stall_cnt", f1_cnt, cnt1 & 16'hffff);
    chk("f0.stall_if", f0_sif, h0);
    chk("f0.stall_id", f0_sid, h0);
    chk("f0.bubble_ex", f0_bub, (h0 || flush) && !rst);
    chk("f0.fwd_rs", f0_frs, 0);
    chk("f0.fwd_rt", f0_frt, 0);
    chk("f0.stall_cnt", f0_cnt, cnt0 & 16'hffff);
    chk("s2.stall_if", s2_sif, h0);
    chk("s2.bubble_ex", s2_bub, (h0 || flush) && !rst);
    chk("s2.stall_cnt", s2_cnt, (cnt0 > 3) ? 3 : cnt0);
  end

  task automatic instr(int rs, int rt, bit urs, bit urt, int rwd, bit wen, bit ld);
    id_rs = rs[4:0]; id_rt = rt[4:0]; id_use_rs = urs; id_use_rt = urt;
    id_rwd = rwd[4:0]; id_wen = wen; id_is_load = ld;
  endtask

  task automatic nop();
    instr(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk); #1;
  endtask

  task automatic drain();
    nop();
    repeat (3) tick();
  endtask

  initial begin
    rst = 1; flush = 0; nop();
    tick();
    chk_en = 1;
    mid();
    chk("rst.stall_if", f1_sif, 0); chk("rst.bubble", f1_bub, 0);
    chk("rst.fwd_rs", f1_frs, 0); chk("rst.cnt", f1_cnt, 0); chk("rst.cnt0", f0_cnt, 0);
    tick();
    rst = 0;

    // add $3,$1,$2 ; sub $4,$3,$5
    instr(1, 2, 1, 1, 3, 1, 0); tick();
    instr(3, 5, 1, 1, 4, 1, 0); mid(); chk("A.nostall", f1_sif, 0); tick();
    nop(); mid(); chk("A.fwd_rs", f1_frs, 1); chk("A.fwd_rt", f1_frt, 0); tick();
    drain();

    // lw $3,0($1) ; add $4,$3,$3
    instr(1, 0, 1, 0, 3, 1, 1); tick();
    instr(3, 3, 1, 1, 4, 1, 0); mid();
    chk("B.stall_if", f1_sif, 1); chk("B.stall_id", f1_sid, 1); chk("B.bubble", f1_bub, 1);
    tick();
    mid(); chk("B.released", f1_sif, 0); tick();
    nop(); mid();
    chk("B.fwd_rs", f1_frs, 2); chk("B.fwd_rt", f1_frt, 2); chk("B.cnt", f1_cnt, 1);
    tick();
    drain();

    // add $3 ; nop ; nop ; or $6,$3,$3 ; then an independent pair
    instr(1, 2, 1, 1, 3, 1, 0); tick();
    nop(); tick(); tick();
    instr(3, 3, 1, 1, 6, 1, 0); mid(); chk("C.nostall", f1_sif, 0); tick();
    nop(); mid(); chk("C.fwd_rs", f1_frs, 0); chk("C.fwd_rt", f1_frt, 0); tick();
    instr(1, 2, 1, 1, 7, 1, 0); tick();
    instr(5, 6, 1, 1, 8, 1, 0); mid(); chk("C.indep", f1_sif, 0); tick();
    nop(); mid(); chk("C.indep_fwd", f1_frs, 0); tick();
    drain();

    // writer $0 ; reader $0
    instr(1, 2, 1, 1, 0, 1, 0); tick();
    instr(0, 0, 1, 1, 4, 1, 0); mid();
    chk("D.f1_nostall", f1_sif, 0); chk("D.f0_nostall", f0_sif, 0); tick();
    nop(); mid(); chk("D.fwd_rs", f1_frs, 0); chk("D.fwd_rt", f1_frt, 0); tick();
    drain();

    // interlock-only: add $3 ; sub $4,$3,$5 -> 3 stall cycles
    rst = 1; tick(); rst = 0;
    instr(1, 2, 1, 1, 3, 1, 0); tick();
    instr(3, 5, 1, 1, 4, 1, 0);
    for (int i = 0; i < 4; i++) begin
      mid(); chk("E.stall", f0_sif, (i < 3) ? 1 : 0); tick();
    end
    nop(); mid(); chk("E.cnt", f0_cnt, 3); chk("E.cnt_w2", s2_cnt, 3); tick();
    drain();

    // load-use with flush in the same cycle
    instr(1, 0, 1, 0, 3, 1, 1); tick();
    instr(3, 3, 1, 1, 4, 1, 0); flush = 1; mid();
    chk("F.stall", f1_sif, 0); chk("F.bubble", f1_bub, 1); tick();
    flush = 0; nop(); mid(); chk("F.after", f1_sif, 0); chk("F.after_bub", f1_bub, 0); tick();
    drain();

    // reset in the middle of an interlock stall
    instr(1, 2, 1, 1, 3, 1, 0); tick();
    instr(3, 5, 1, 1, 4, 1, 0); mid(); chk("G.stalling", f0_sif, 1); tick();
    rst = 1; tick(); rst = 0;
    mid();
    chk("G.stall_if", f0_sif, 0); chk("G.bubble", f0_bub, 0); chk("G.cnt", f0_cnt, 0);
    tick();
    drain();

    // saturation: 6 stalls into a 2-bit counter
    rst = 1; tick(); rst = 0;
    instr(1, 2, 1, 1, 3, 1, 0); tick();
    instr(3, 5, 1, 1, 4, 1, 0); repeat (4) tick();
    instr(1, 2, 1, 1, 5, 1, 0); tick();
    instr(5, 5, 1, 1, 6, 1, 0); repeat (4) tick();
    nop(); mid(); chk("H.sat", s2_cnt, 3); chk("H.cnt16", f0_cnt, 6); tick();
    drain();

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
